// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the CPU (A, priority) and a loader (B); same-cycle grant,
// read data one cycle later, the losing requester simply waits. Optional statistics: DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
   parameter int AW        = 16,
   parameter int DW        = 16,
   parameter int MAX_WAIT  = 4,
   parameter int MAX_BURST = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_stall,
   output logic [DW-1:0] a_rdata,
   output logic          a_rvalid,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   input  logic          b_lock,
   output logic          b_gnt,
   output logic [DW-1:0] b_rdata,
   output logic          b_rvalid,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_write,
   output logic          mem_read,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    owner
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [15:0]   conflict_cnt,
   output logic          starve_evt
`endif
);

   localparam int WCW = $clog2(MAX_WAIT + 1);
   localparam int BCW = $clog2(MAX_BURST + 1);
   localparam logic [WCW-1:0] WAIT_TOP  = WCW'(MAX_WAIT);
   localparam logic [BCW-1:0] BURST_TOP = BCW'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      A_OWN   = 2'b01,
      B_BURST = 2'b10
   } owner_t;

   owner_t         state_q, state_d;
   logic [WCW-1:0] wait_q, wait_d;
   logic [BCW-1:0] burst_q, burst_d;
   logic           force_b, hold_b;

   assign owner = state_q;

   // Grants are blanked while reset is low so nothing reaches memory during reset.
   always_comb begin
      force_b   = b_req & (wait_q == WAIT_TOP);
      hold_b    = (state_q == B_BURST) & b_req & b_lock & (burst_q < BURST_TOP);
      b_gnt     = reset & b_req & (~a_req | force_b | hold_b);
      a_gnt     = reset & a_req & ~b_gnt;
      a_stall   = a_req & ~a_gnt;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      if (a_gnt) begin
         mem_addr  = a_addr;
         mem_wdata = a_wdata;
         mem_write = a_we;
         mem_read  = ~a_we;
      end else if (b_gnt) begin
         mem_addr  = b_addr;
         mem_wdata = b_wdata;
         mem_write = b_we;
         mem_read  = ~b_we;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      burst_d = burst_q;
      if (b_gnt) begin
         wait_d = '0;
         if (b_lock) begin
            state_d = B_BURST;
            if (state_q != B_BURST)
               burst_d = BCW'(1);
            else if (burst_q != BURST_TOP)
               burst_d = burst_q + BCW'(1);
         end else begin
            state_d = IDLE;
            burst_d = '0;
         end
      end else begin
         if (!b_req)
            wait_d = '0;
         else if (wait_q != WAIT_TOP)
            wait_d = wait_q + WCW'(1);
         // A winning against a saturated burst is the forced release.
         state_d = a_gnt ? A_OWN : IDLE;
         burst_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         wait_q   <= '0;
         burst_q  <= '0;
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         burst_q  <= burst_d;
         a_rvalid <= a_gnt & ~a_we;
         b_rvalid <= b_gnt & ~b_we;
         if (a_gnt && !a_we)
            a_rdata <= mem_rdata;
         if (b_gnt && !b_we)
            b_rdata <= mem_rdata;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset) begin
         conflict_cnt <= '0;
         starve_evt   <= 1'b0;
      end else begin
         if (a_req && b_req)
            conflict_cnt <= conflict_cnt + 16'd1;
         starve_evt <= b_gnt & force_b;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed table, hand-written burst/reset sequences, then random traffic
// checked every cycle against an integer-level reference model of the arbitration rules.
module tb_dmem_port_arbiter;
   localparam int MAX_WAIT  = 4;
   localparam int MAX_BURST = 8;

   logic        clock = 1'b0;
   logic        reset, a_req, a_we, b_req, b_we, b_lock;
   logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_gnt, a_stall, a_rvalid, b_gnt, b_rvalid;
   logic [15:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_write, mem_read;
   logic [1:0]  owner;
`ifdef DMEM_ARB_STATS_EN
   logic [15:0] conflict_cnt;
   logic        starve_evt;
`endif

   always #5 clock = ~clock;

   dmem_port_arbiter #(.AW(16), .DW(16), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_stall(a_stall), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
      .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata), .owner(owner)
`ifdef DMEM_ARB_STATS_EN
      , .conflict_cnt(conflict_cnt), .starve_evt(starve_evt)
`endif
   );

   // Physical memory seen by the DUT and the model's own view of memory contents.
   logic [15:0] phys    [256];
   logic [15:0] mdl_mem [256];
   assign mem_rdata = phys[mem_addr[7:0]];

   int          m_owner, m_wait, m_burst, m_conf;
   bit          m_arv, m_brv, m_starve, regs_known;
   logic [15:0] m_ard, m_brd;
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs, compare at the falling edge, then advance the model.
   task automatic step(input bit rst, input bit ar, input bit aw, input logic [15:0] aa, input logic [15:0] ad,
                       input bit br, input bit bw, input bit bl, input logic [15:0] ba, input logic [15:0] bd);
      bit          ea, eb, frc, hld;
      logic [15:0] e_addr, e_wdata;
      @(posedge clock);
      if (mem_write) phys[mem_addr[7:0]] = mem_wdata;
      #1;
      reset = rst; a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
      b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
      @(negedge clock);
      frc     = br && (m_wait == MAX_WAIT);
      hld     = (m_owner == 2) && br && bl && (m_burst < MAX_BURST);
      eb      = rst && br && (!ar || frc || hld);
      ea      = rst && ar && !eb;
      e_addr  = ea ? aa : (eb ? ba : 16'h0);
      e_wdata = ea ? ad : (eb ? bd : 16'h0);
      if (regs_known) begin
         chk("owner", 32'(owner), 32'(m_owner));
         chk("a_rvalid", 32'(a_rvalid), 32'(m_arv));
         chk("b_rvalid", 32'(b_rvalid), 32'(m_brv));
         chk("a_rdata", 32'(a_rdata), 32'(m_ard));
         chk("b_rdata", 32'(b_rdata), 32'(m_brd));
`ifdef DMEM_ARB_STATS_EN
         chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
         chk("starve_evt", 32'(starve_evt), 32'(m_starve));
`endif
      end
      chk("a_gnt", 32'(a_gnt), 32'(ea));
      chk("b_gnt", 32'(b_gnt), 32'(eb));
      chk("a_stall", 32'(a_stall), 32'(ar && !ea));
      chk("mem_write", 32'(mem_write), 32'((ea && aw) || (eb && bw)));
      chk("mem_read", 32'(mem_read), 32'((ea && !aw) || (eb && !bw)));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      if (!rst) begin
         m_owner = 0; m_wait = 0; m_burst = 0; m_conf = 0; m_starve = 0;
         m_arv = 0; m_brv = 0; m_ard = 16'h0; m_brd = 16'h0;
         regs_known = 1;
      end else begin
         if (ar && br) m_conf = (m_conf + 1) % 65536;
         m_starve = eb && frc;
         m_arv = ea && !aw;
         m_brv = eb && !bw;
         if (m_arv) m_ard = mdl_mem[aa[7:0]];
         if (m_brv) m_brd = mdl_mem[ba[7:0]];
         if (ea && aw) mdl_mem[aa[7:0]] = ad;
         if (eb && bw) mdl_mem[ba[7:0]] = bd;
         m_wait = (eb || !br) ? 0 : ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT);
         if (eb && bl) begin
            if (m_owner == 2) m_burst = (m_burst < MAX_BURST) ? m_burst + 1 : MAX_BURST;
            else begin m_owner = 2; m_burst = 1; end
         end else if (eb) begin
            m_owner = 0; m_burst = 0;
         end else if (ea) begin
            m_owner = 1; m_burst = 0;
         end else begin
            m_owner = 0; m_burst = 0;
         end
      end
   endtask

   typedef struct {
      bit rst, ar, aw; logic [15:0] aa, ad;
      bit br, bw, bl;  logic [15:0] ba, bd;
      bit eag, ebg, emw, chkr; logic [1:0] eown; bit earv, ebrv; logic [15:0] erd;
   } vec_t;
   vec_t tbl [21];

   initial begin
      int nb, n_st;
      bit a_done, lk;
      reset = 0; a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
      regs_known = 0; m_owner = 0; m_wait = 0; m_burst = 0; m_conf = 0; m_starve = 0;
      m_arv = 0; m_brv = 0; m_ard = 0; m_brd = 0;
      for (int i = 0; i < 256; i++) begin
         phys[i]    = 16'(i * 7 + 16'h0100);
         mdl_mem[i] = phys[i];
      end
      phys[2] = 16'hBEEF; mdl_mem[2] = 16'hBEEF;
      phys[3] = 16'h0042; mdl_mem[3] = 16'h0042;

      // rst ar aw aa ad | br bw bl ba bd | a_gnt b_gnt mem_write chk_regs owner a_rvalid b_rvalid rdata
      tbl[0]  = '{0,1,1,16'h5,16'h1234, 0,0,0,16'h0,16'h0, 0,0,0, 0,2'd0,0,0,16'h0};
      tbl[1]  = '{0,1,1,16'h5,16'h1234, 0,0,0,16'h0,16'h0, 0,0,0, 1,2'd0,0,0,16'h0};
      tbl[2]  = '{1,1,1,16'h5,16'h1234, 0,0,0,16'h0,16'h0, 1,0,1, 1,2'd0,0,0,16'h0};
      tbl[3]  = '{1,1,0,16'h5,16'h0,    0,0,0,16'h0,16'h0, 1,0,0, 1,2'd1,0,0,16'h0};
      tbl[4]  = '{1,0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0, 0,0,0, 1,2'd1,1,0,16'h1234};
      tbl[5]  = '{1,0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0, 0,0,0, 1,2'd0,0,0,16'h0};
      tbl[6]  = '{1,1,0,16'h3,16'h0,    1,0,0,16'h2,16'h0, 1,0,0, 1,2'd0,0,0,16'h0};
      tbl[7]  = '{1,1,0,16'h3,16'h0,    1,0,0,16'h2,16'h0, 1,0,0, 1,2'd1,1,0,16'h0042};
      tbl[8]  = '{1,1,0,16'h3,16'h0,    1,0,0,16'h2,16'h0, 1,0,0, 1,2'd1,1,0,16'h0042};
      tbl[9]  = '{1,1,0,16'h3,16'h0,    1,0,0,16'h2,16'h0, 1,0,0, 1,2'd1,1,0,16'h0042};
      tbl[10] = '{1,1,0,16'h3,16'h0,    1,0,0,16'h2,16'h0, 0,1,0, 1,2'd1,1,0,16'h0042};
      tbl[11] = '{1,1,0,16'h3,16'h0,    1,0,0,16'h2,16'h0, 1,0,0, 1,2'd0,0,1,16'hBEEF};
      tbl[12] = '{1,1,0,16'h3,16'h0,    1,0,0,16'h2,16'h0, 1,0,0, 1,2'd1,1,0,16'h0042};
      tbl[13] = '{1,1,0,16'h3,16'h0,    1,0,0,16'h2,16'h0, 1,0,0, 1,2'd1,1,0,16'h0042};
      tbl[14] = '{1,1,0,16'h3,16'h0,    1,0,0,16'h2,16'h0, 1,0,0, 1,2'd1,1,0,16'h0042};
      tbl[15] = '{1,1,0,16'h3,16'h0,    1,0,0,16'h2,16'h0, 0,1,0, 1,2'd1,1,0,16'h0042};
      tbl[16] = '{1,0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0, 0,0,0, 1,2'd0,0,1,16'hBEEF};
      tbl[17] = '{1,0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0, 0,0,0, 1,2'd0,0,0,16'h0};
      tbl[18] = '{1,0,0,16'h0,16'h0,    1,0,0,16'h2,16'h0, 0,1,0, 1,2'd0,0,0,16'h0};
      tbl[19] = '{1,1,0,16'h3,16'h0,    0,0,0,16'h0,16'h0, 1,0,0, 1,2'd0,0,1,16'hBEEF};
      tbl[20] = '{1,0,0,16'h0,16'h0,    0,0,0,16'h0,16'h0, 0,0,0, 1,2'd1,1,0,16'h0042};

      for (int i = 0; i < 21; i++) begin
         step(tbl[i].rst, tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad,
              tbl[i].br, tbl[i].bw, tbl[i].bl, tbl[i].ba, tbl[i].bd);
         chk("tbl_a_gnt", 32'(a_gnt), 32'(tbl[i].eag));
         chk("tbl_b_gnt", 32'(b_gnt), 32'(tbl[i].ebg));
         chk("tbl_mem_write", 32'(mem_write), 32'(tbl[i].emw));
         if (tbl[i].chkr) begin
            chk("tbl_owner", 32'(owner), 32'(tbl[i].eown));
            chk("tbl_a_rvalid", 32'(a_rvalid), 32'(tbl[i].earv));
            chk("tbl_b_rvalid", 32'(b_rvalid), 32'(tbl[i].ebrv));
         end
         if (tbl[i].earv) chk("tbl_a_rdata", 32'(a_rdata), 32'(tbl[i].erd));
         if (tbl[i].ebrv) chk("tbl_b_rdata", 32'(b_rdata), 32'(tbl[i].erd));
      end

      // Locked B burst over addresses 0..9, A arrives on the third beat.
      nb = 0; a_done = 0;
      for (int c = 0; c < 14; c++) begin
         bit ar;
         ar = (nb >= 2) && !a_done;
         step(1, ar, 0, 16'h0007, 16'h0, nb < 10, 0, 1, 16'(nb), 16'h0);
         if (nb < MAX_BURST) chk("burst_b_beat", 32'(b_gnt), 32'd1);
         else if (ar) chk("burst_release_a", 32'(a_gnt), 32'd1);
         else if (nb < 10) chk("burst_resume_b", 32'(b_gnt), 32'd1);
         if (a_gnt) a_done = 1;
         if (b_gnt) nb++;
      end
      chk("burst_total_beats", 32'(nb), 32'd10);

      // Reset while B owns the port with a read return pending.
      step(1, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h2, 16'h0);
      step(1, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h3, 16'h0);
      step(0, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h4, 16'h0);
      chk("rst_burst_owner_before", 32'(owner), 32'd2);
      chk("rst_burst_rvalid_before", 32'(b_rvalid), 32'd1);
      chk("rst_burst_no_read", 32'(mem_read), 32'd0);
      step(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
      chk("rst_burst_owner_after", 32'(owner), 32'd0);
      chk("rst_burst_rvalid_after", 32'(b_rvalid), 32'd0);

`ifdef DMEM_ARB_STATS_EN
      step(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
      n_st = 0;
      for (int c = 0; c < 11; c++) begin
         step(1, c < 10, 0, 16'h3, 16'h0, c < 10, 0, 0, 16'h2, 16'h0);
         if (starve_evt) n_st++;
      end
      chk("stats_conflict_10", 32'(conflict_cnt), 32'd10);
      chk("stats_starve_pulses", 32'(n_st), 32'd2);
`else
      n_st = 0;
`endif

      lk = 0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 9) == 0) lk = ~lk;
         step($urandom_range(0, 49) != 0,
              $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
              16'($urandom_range(0, 15)), 16'($urandom),
              $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, lk,
              16'($urandom_range(0, 15)), 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (DMemory_IO-style: 16-bit addr/wdata/rdata, write and read enables) between two requesters.
  - Port A: PMIPS CPU.
  - Port B: loader/debug master.
- Grants are same-cycle; read data is registered and returns with a one-cycle `rvalid` pulse.
- Port A has priority. A starvation counter guarantees B service, and a burst lock lets B hold the port for bounded back-to-back transfers.
- Sits between the PMIPSL0 data-memory pins and the data memory device.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MAX_WAIT, 4, consecutive cycles B may be denied before B is forced a grant (≥1).
- MAX_BURST, 8, maximum consecutive B grants under b_lock before one forced release cycle (≥1).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- a_req  in  1  CPU access request.
- a_we  in  1  CPU write (1) / read (0).
- a_addr  in  AW  CPU address.
- a_wdata  in  DW  CPU write data.
- a_gnt  out  1  CPU access performed this cycle (combinational).
- a_stall  out  1  a_req & ~a_gnt.
- a_rdata  out  DW  registered read data for A.
- a_rvalid  out  1  one-cycle pulse, A read data valid.
- b_req, b_we, b_addr, b_wdata  in  1/1/AW/DW  loader request bundle.
- b_lock  in  1  loader requests burst ownership.
- b_gnt  out  1  loader access performed this cycle (combinational).
- b_rdata  out  DW  registered read data for B.
- b_rvalid  out  1  one-cycle pulse, B read data valid.
- mem_addr  out  AW  to memory.
- mem_wdata  out  DW  to memory.
- mem_write  out  1  to memory.
- mem_read  out  1  to memory.
- mem_rdata  in  DW  memory read data (combinational from mem_addr).
- owner  out  2  registered state: 00 IDLE, 01 A_OWN, 10 B_BURST.

Behaviour:
- State machine on registered `owner`, plus `wait_cnt` (0..MAX_WAIT) and `burst_cnt` (0..MAX_BURST).
- Grant decision (combinational, per cycle):
  - `force_b` = b_req & (wait_cnt == MAX_WAIT).
  - `hold_b` = owner==B_BURST & b_req & b_lock & burst_cnt < MAX_BURST.
  - `b_gnt` = b_req & (~a_req | force_b | hold_b).
  - `a_gnt` = a_req & ~b_gnt.
  - At most one grant per cycle; never both.
- Memory drive:
  - mem_* comes from the granted bundle.
  - mem_write = gnt & we.
  - mem_read = gnt & ~we.
  - With no grant: mem_addr = 0, mem_wdata = 0, mem_write = mem_read = 0.
- Read return:
  - On a granted read, the corresponding x_rdata <= mem_rdata and x_rvalid = 1 for the next cycle only.
  - x_rdata holds its value otherwise.
  - Writes never pulse rvalid.
- wait_cnt:
  - Cleared when b_gnt or ~b_req.
  - Incremented (saturating at MAX_WAIT) when b_req & ~b_gnt.
- State transitions:
  - IDLE/A_OWN → B_BURST when b_gnt & b_lock, with burst_cnt <= 1.
  - B_BURST & b_gnt & b_lock → stay in B_BURST, burst_cnt++ (saturating at MAX_BURST).
  - B_BURST with burst_cnt == MAX_BURST & a_req → A is granted (forced release); state → A_OWN, burst_cnt <= 0.
  - B_BURST with burst_cnt == MAX_BURST & ~a_req → B may continue. burst_cnt stays saturated, so the next cycle A arrives it wins.
  - b_gnt & ~b_lock from any state → IDLE.
  - a_gnt → A_OWN.
  - No grant → IDLE, burst_cnt <= 0.
- Reset (reset==0 at a clock edge): owner=IDLE, wait_cnt=0, burst_cnt=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - Combinational grants during reset are forced to 0, so memory is not written while reset is asserted.
  - Reset mid-burst drops ownership. Any pending rvalid is cleared.
- A request deasserted mid-wait simply loses its slot. The arbiter keeps no request queue.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds output `conflict_cnt` [15:0], counting cycles with a_req & b_req. It wraps at 0xFFFF→0 and resets to 0.
  - Adds output `starve_evt`, a one-cycle registered pulse the cycle after any force_b grant.
- Undefined: these ports and their logic do not exist. Grant behaviour is identical either way.

Test Plan:
- Reset held low 2 cycles with a_req=1, a_we=1 → mem_write=0, a_gnt=0, all outputs 0. After release, A write to addr 5 data 0x1234 → mem_write=1 the same cycle; a later A read of addr 5 → a_rvalid next cycle, a_rdata=0x1234.
- A and B request continuously, MAX_WAIT=4, b_lock=0 → A granted 4 cycles, B granted on cycle 5, pattern repeats (4:1). wait_cnt returns to 0 after each B grant.
- B alone, b_lock=1, reads addr 0..9; A asserts at beat 3 → B keeps grants through beat 8 (burst_cnt=8), A granted on the next cycle, then B resumes.
- Single read on each port in consecutive cycles: B reads addr 2 (0xBEEF), then A reads addr 3 (0x0042) → b_rvalid then a_rvalid on successive cycles, no cross-contamination of rdata.
- Reset asserted while owner=B_BURST and b_rvalid pending → next cycle owner=IDLE, b_rvalid=0, burst_cnt=0.
- With DMEM_ARB_STATS_EN: 10 overlap cycles → conflict_cnt=10, and starve_evt pulses twice (MAX_WAIT=4).
